// File: rtl/frame_read_sequencer_if.sv
// Bundle of configuration, read-master and output-stream signals of frame_read_sequencer.
// master = sequencer side, slave = surrounding system (config host, read master, sink).
interface frame_read_sequencer_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BURST_WIDTH   = 4,
    parameter int unsigned LENGTH_WIDTH  = 24
);
    logic                     cfg_start;
    logic [ADDRESS_WIDTH-1:0] cfg_base;
    logic [LENGTH_WIDTH-1:0]  cfg_words;
    logic                     cfg_busy;
    logic                     cfg_done;
    logic                     overflow;

    logic                     rd_start;
    logic [ADDRESS_WIDTH-1:0] rd_baseaddress;
    logic [BURST_WIDTH-1:0]   rd_burstcount;
    logic                     rd_busy;
    logic                     rd_readdatavalid;
    logic [DATA_WIDTH-1:0]    rd_readdata;

    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_sof;
    logic                     out_eof;
    logic                     out_ready;

    modport master (
        input  cfg_start, cfg_base, cfg_words, rd_busy, rd_readdatavalid, rd_readdata, out_ready,
        output cfg_busy, cfg_done, overflow, rd_start, rd_baseaddress, rd_burstcount,
               out_valid, out_data, out_sof, out_eof
    );

    modport slave (
        output cfg_start, cfg_base, cfg_words, rd_busy, rd_readdatavalid, rd_readdata, out_ready,
        input  cfg_busy, cfg_done, overflow, rd_start, rd_baseaddress, rd_burstcount,
               out_valid, out_data, out_sof, out_eof
    );
endinterface

// File: rtl/frame_read_sequencer.sv
// Splits a frame read into bursts, reserves FIFO space per burst before issuing it, and
// streams the returned words out with start/end-of-frame markers.
module frame_read_sequencer #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned BURST_WIDTH    = 4,
    parameter int unsigned BURST_LEN      = 8,
    parameter int unsigned LENGTH_WIDTH   = 24,
    parameter int unsigned FIFO_DEPTH     = 32,
    parameter int unsigned FIFO_AW        = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_read_sequencer_if.master bus
);
    localparam int unsigned CntW  = FIFO_AW + 1;
    localparam int unsigned UsedW = CntW + 1;

    typedef enum logic [2:0] {
        StIdle, StCheck, StIssue, StWaitAck, StWaitDone, StFlush
    } state_e;

    state_e                   state_q;
    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]          count_q, outstanding_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, rd_baseaddress_q;
    logic [LENGTH_WIDTH-1:0]  remaining_q, frame_words_q, out_cnt_q;
    logic [BURST_WIDTH-1:0]   rd_burstcount_q;
    logic                     cfg_busy_q, cfg_done_q, overflow_q, rd_start_q, drained_q;

    logic                     out_valid, rd_en, full, has_pending, wr_en, data_dec;
    logic                     out_sof, out_eof, eof_xfer, fits, issue;
    logic [LENGTH_WIDTH-1:0]  len;
    logic [CntW-1:0]          len_c;
    logic [UsedW-1:0]         used;

    always_comb begin
        out_valid   = count_q != '0;
        rd_en       = out_valid & bus.out_ready;
        full        = count_q == CntW'(FIFO_DEPTH);
        has_pending = outstanding_q != '0;
        // A word is only kept if a slot was reserved for it and the FIFO can take it.
        wr_en       = bus.rd_readdatavalid & has_pending & (~full | rd_en);
        data_dec    = bus.rd_readdatavalid & has_pending;
        len         = (remaining_q < LENGTH_WIDTH'(BURST_LEN)) ? remaining_q
                                                               : LENGTH_WIDTH'(BURST_LEN);
        len_c       = CntW'(len);
        used        = UsedW'(count_q) + UsedW'(outstanding_q) + UsedW'(len_c);
        fits        = used <= UsedW'(FIFO_DEPTH);
        issue       = (state_q == StCheck) && (remaining_q != '0) && fits;
        out_sof     = out_valid & cfg_busy_q & (out_cnt_q == '0);
        out_eof     = out_valid & cfg_busy_q &
                      (out_cnt_q == frame_words_q - LENGTH_WIDTH'(1));
        eof_xfer    = rd_en & out_eof;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.rd_readdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q       <= count_q + CntW'(wr_en) - CntW'(rd_en);
            outstanding_q <= outstanding_q + (issue ? len_c : '0) - CntW'(data_dec);
            if (bus.rd_readdatavalid && !wr_en) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            cfg_busy_q       <= 1'b0;
            cfg_done_q       <= 1'b0;
            rd_start_q       <= 1'b0;
            rd_baseaddress_q <= '0;
            rd_burstcount_q  <= '0;
            addr_q           <= '0;
            remaining_q      <= '0;
            frame_words_q    <= '0;
            out_cnt_q        <= '0;
            drained_q        <= 1'b0;
        end else begin
            cfg_done_q <= 1'b0;
            rd_start_q <= 1'b0;
            if (eof_xfer) begin
                cfg_busy_q <= 1'b0;
                cfg_done_q <= 1'b1;
                out_cnt_q  <= '0;
                drained_q  <= 1'b1;
            end else if (rd_en && cfg_busy_q) begin
                out_cnt_q <= out_cnt_q + LENGTH_WIDTH'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.cfg_start && !cfg_busy_q) begin
                        if (bus.cfg_words == '0) begin
                            cfg_done_q <= 1'b1;
                        end else begin
                            state_q       <= StCheck;
                            cfg_busy_q    <= 1'b1;
                            addr_q        <= bus.cfg_base;
                            remaining_q   <= bus.cfg_words;
                            frame_words_q <= bus.cfg_words;
                            out_cnt_q     <= '0;
                            drained_q     <= 1'b0;
                        end
                    end
                end
                StCheck: begin
                    if (remaining_q == '0) begin
                        state_q <= StFlush;
                    end else if (fits) begin
                        state_q          <= StIssue;
                        rd_start_q       <= 1'b1;
                        rd_baseaddress_q <= addr_q;
                        rd_burstcount_q  <= BURST_WIDTH'(len);
                        addr_q           <= addr_q + ADDRESS_WIDTH'(len_c) *
                                                     ADDRESS_WIDTH'(BYTES_PER_WORD);
                        remaining_q      <= remaining_q - len;
                    end
                end
                StIssue:    state_q <= StWaitAck;
                StWaitAck:  if (bus.rd_busy) state_q <= StWaitDone;
                StWaitDone: if (!bus.rd_busy) state_q <= StCheck;
                StFlush:    if (drained_q || eof_xfer) state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_busy       = cfg_busy_q;
    assign bus.cfg_done       = cfg_done_q;
    assign bus.overflow       = overflow_q;
    assign bus.rd_start       = rd_start_q;
    assign bus.rd_baseaddress = rd_baseaddress_q;
    assign bus.rd_burstcount  = rd_burstcount_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_data       = mem_q[rd_ptr_q];
    assign bus.out_sof        = out_sof;
    assign bus.out_eof        = out_eof;
endmodule

// File: doc/frame_read_sequencer.md
Name: frame_read_sequencer

Overview:
Sits directly downstream of the burst read master. Splits a frame-sized read request (base address, word count) into bursts of at most BURST_LEN words and issues them over the master's ctrl_* handshake. Returned words are collected in an internal FIFO and presented as a valid/ready stream with start/end-of-frame markers. A new burst is issued only when FIFO space for the whole burst is already reserved, so read data is never dropped.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
BYTES_PER_WORD, 4, address increment per word
BURST_WIDTH, 4, width of burst count field (must hold BURST_LEN)
BURST_LEN, 8, maximum words per burst
LENGTH_WIDTH, 24, width of frame word count
FIFO_DEPTH, 32, FIFO entries (power of 2, >= BURST_LEN)
FIFO_AW, 5, log2(FIFO_DEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_start  in  1  frame request strobe
cfg_base  in  ADDRESS_WIDTH  frame byte base address
cfg_words  in  LENGTH_WIDTH  frame length in words
cfg_busy  out  1  frame in progress
cfg_done  out  1  one-cycle pulse when the last frame word leaves the stream
overflow  out  1  sticky: data arrived with no reserved slot
rd_start  out  1  one-cycle burst start to the read master
rd_baseaddress  out  ADDRESS_WIDTH  burst byte address
rd_burstcount  out  BURST_WIDTH  burst length in words
rd_busy  in  1  read master busy
rd_readdatavalid  in  1  returned word valid
rd_readdata  in  DATA_WIDTH  returned word
out_valid  out  1  stream word valid
out_data  out  DATA_WIDTH  stream word
out_sof  out  1  marks first word of frame (qualified by out_valid)
out_eof  out  1  marks last word of frame (qualified by out_valid)
out_ready  in  1  downstream accepts

Behaviour:
- Reset (async): all outputs 0; FIFO empty; state IDLE; all counters 0; overflow cleared.
- cfg_start in IDLE latches base/words; cfg_busy=1 next cycle. cfg_start ignored while cfg_busy=1.
- cfg_words=0: cfg_busy stays 0, cfg_done pulses 1 cycle after cfg_start, no bursts issued.
- Issue-side FSM: IDLE -> CHECK -> ISSUE -> WAIT_ACK -> WAIT_DONE -> CHECK ... -> FLUSH -> IDLE.
  - CHECK: len = min(BURST_LEN, remaining_issue). If remaining_issue=0 go FLUSH. Else if free >= len go ISSUE, else stay.
  - free = FIFO_DEPTH - fifo_count - outstanding; outstanding = words issued but not yet received.
  - ISSUE: rd_start=1 for exactly one cycle, rd_baseaddress=current address, rd_burstcount=len; outstanding += len; address += len*BYTES_PER_WORD (wraps modulo 2^ADDRESS_WIDTH); remaining_issue -= len.
  - WAIT_ACK: wait for rd_busy=1. WAIT_DONE: wait for rd_busy=0, then CHECK.
  - FLUSH: wait until all frame words have left the stream, then IDLE.
- Each rd_readdatavalid cycle: write rd_readdata to FIFO, outstanding -= 1. If outstanding=0 or the FIFO is full and not read in the same cycle: word dropped, overflow=1 (sticky until reset).
- FIFO is first-word-fall-through: out_valid = not empty; transfer on out_valid & out_ready. Same-cycle write and read are legal at full and at any nonzero occupancy; count unchanged.
- Output word counter: out_sof=1 when counter=0, out_eof=1 when counter=frame_words-1. On the eof transfer: cfg_done pulses the next cycle, cfg_busy falls the same cycle, counter clears.
- Latency: rd_start no earlier than 2 cycles after cfg_start; FIFO write-to-out_valid is 1 cycle.
- Reset mid-frame aborts everything, discards FIFO contents, and drives rd_start=0 immediately.

Test Plan:
- base=0x39000000, words=16, out_ready=1: two bursts at 0x39000000 and 0x39000020, count 8 each; 16 words in order; sof on word 0, eof on word 15; single cfg_done.
- words=13: bursts of 8 then 5 (second at 0x39000020); eof on word 12.
- FIFO_DEPTH=32, words=64, out_ready=0: exactly 4 bursts issued, then stall; out_ready=1 resumes; all 64 words delivered; overflow=0.
- words=0: no rd_start; cfg_done pulses once; cfg_busy stays 0.
- Spurious rd_readdatavalid in IDLE: overflow=1; no stream output.
- Reset asserted during the second burst: all outputs 0 at once; a new start after reset runs cleanly.
